// File: rtl/hex_word_ascii_streamer.sv
// ============================================================================
//  Module      : hex_word_ascii_streamer
//  Description : Accepts one DATA_W-bit word on a valid/ready input and streams
//                its hexadecimal ASCII text, one byte per handshake and MSB
//                nibble first. Leading zero nibbles can be trimmed per word,
//                and the digits can optionally be followed by CR LF.
//                Optional "0x" prefix: define HEX_STREAM_PREFIX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_word_ascii_streamer #(
  parameter int DATA_W  = 32,
  parameter int NEWLINE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_trim,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              busy
);

  // Number of hex digits in a word and the width of the digit index.
  localparam int NIB  = DATA_W / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  // State encoding.
  localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef HEX_STREAM_PREFIX_EN
  localparam logic [2:0] S_PREFIX0 = 3'd1;
  localparam logic [2:0] S_PREFIX1 = 3'd2;
`endif
  localparam logic [2:0] S_DIGITS  = 3'd3;
  localparam logic [2:0] S_CR      = 3'd4;
  localparam logic [2:0] S_LF      = 3'd5;

  // Fixed ASCII codes.
  localparam logic [7:0] C_NUL = 8'h00;
  localparam logic [7:0] C_CR  = 8'h0D;
  localparam logic [7:0] C_LF  = 8'h0A;
`ifdef HEX_STREAM_PREFIX_EN
  localparam logic [7:0] C_ZERO = 8'h30;
  localparam logic [7:0] C_X    = 8'h78;
`endif

  // Registered state.
  logic [2:0]        r_state;
  logic [IDXW-1:0]   r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_out_valid;
  logic [7:0]        r_out_char;

  // Combinational next values.
  logic [2:0]        w_state_nxt;
  logic [IDXW-1:0]   w_idx_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_valid_nxt;
  logic [7:0]        w_char_nxt;
  logic [3:0]        w_nib_nxt;
  logic [IDXW-1:0]   w_msnz;
  logic [IDXW-1:0]   w_start;
  logic              w_out_hs;

  // Uppercase hex digit to ASCII: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, nib};
    end else begin
      hex_ascii = 8'h37 + {4'h0, nib};
    end
  endfunction

  assign w_out_hs = r_out_valid & out_ready;

  // First digit to print: the top nibble, or the most significant nonzero
  // nibble when trimming (index 0 for a zero word so "0" is still printed).
  always_comb begin
    w_msnz = '0;
    for (int i = 0; i < NIB; i++) begin
      if (in_data[i*4 +: 4] != 4'h0) begin
        w_msnz = IDXW'(i);
      end
    end
    w_start = in_trim ? w_msnz : IDXW'(NIB - 1);
  end

  // State, digit index and word registers; cleared asynchronously so a reset
  // mid-stream drops the rest of the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state logic: accept only in IDLE, advance only on output handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_data_nxt = in_data;
          w_idx_nxt  = w_start;
`ifdef HEX_STREAM_PREFIX_EN
          w_state_nxt = S_PREFIX0;
`else
          w_state_nxt = S_DIGITS;
`endif
        end
      end
`ifdef HEX_STREAM_PREFIX_EN
      S_PREFIX0: begin
        if (w_out_hs) begin
          w_state_nxt = S_PREFIX1;
        end
      end
      S_PREFIX1: begin
        if (w_out_hs) begin
          w_state_nxt = S_DIGITS;
        end
      end
`endif
      S_DIGITS: begin
        if (w_out_hs) begin
          if (r_idx == '0) begin
            w_state_nxt = (NEWLINE != 0) ? S_CR : S_IDLE;
          end else begin
            w_idx_nxt = r_idx - IDXW'(1);
          end
        end
      end
      S_CR: begin
        if (w_out_hs) begin
          w_state_nxt = S_LF;
        end
      end
      S_LF: begin
        if (w_out_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: the byte for the state being entered, so the registered
  // output lines up with the state. While stalled nothing changes, so the
  // byte is recomputed identically and holds.
  always_comb begin
    w_nib_nxt = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (w_idx_nxt == IDXW'(i)) begin
        w_nib_nxt = w_data_nxt[i*4 +: 4];
      end
    end
    w_valid_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
`ifdef HEX_STREAM_PREFIX_EN
      S_PREFIX0: w_char_nxt = C_ZERO;
      S_PREFIX1: w_char_nxt = C_X;
`endif
      S_DIGITS:  w_char_nxt = hex_ascii(w_nib_nxt);
      S_CR:      w_char_nxt = C_CR;
      S_LF:      w_char_nxt = C_LF;
      default:   w_char_nxt = C_NUL;
    endcase
  end

  // Output byte register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_char  <= C_NUL;
    end else begin
      r_out_valid <= w_valid_nxt;
      r_out_char  <= w_char_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hex_word_ascii_streamer.sv
// ============================================================================
//  Module      : tb_hex_word_ascii_streamer
//  Description : Scoreboard bench for hex_word_ascii_streamer (DATA_W=32,
//                NEWLINE=1). Expected bytes are queued when a word is issued
//                and a monitor pops them on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_word_ascii_streamer;

  localparam int DATA_W  = 32;
  localparam int NEWLINE = 1;
`ifdef HEX_STREAM_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_trim;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_char;
  logic              busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_hs    = 0;
  logic [7:0] exp_q[$];
  bit         bp_en   = 1'b0;
  logic [15:0] bp_pat = 16'hB269;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_char  = 8'h00;

  hex_word_ascii_streamer #(
    .DATA_W  (DATA_W),
    .NEWLINE (NEWLINE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_trim   (in_trim),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Push n bytes, first byte in the most significant position of v.
  task automatic push_seq(input int n, input logic [79:0] v);
`ifdef HEX_STREAM_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(v[8*(n-1-k) +: 8]);
    end
  endtask

  // Present a word and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [31:0] d, input bit t);
    int guard;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_trim  = t;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) timeout_fail("send_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid || !in_ready) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) timeout_fail(name);
  endtask

  // Downstream ready: always 1, or a fixed stall pattern when backpressure is on.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      out_ready = bp_pat[0];
      bp_pat    = {bp_pat[0], bp_pat[15:1]};
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: hold-stability while stalled, scoreboard compare on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        check_eq("stall_char_hold", {24'd0, out_char}, {24'd0, prev_char});
      end
      if (out_valid && out_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_byte");
          $display("  extra byte %0h", out_char);
        end else begin
          check_eq("byte", {24'd0, out_char}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_trim  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_char", {24'd0, out_char}, 32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full word, no trim, back-to-back bytes
    push_seq(10, {8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A});
    send(32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 10 + PFX; k++) begin
      @(negedge clk);
      check_eq("deadbeef_consecutive_valid", {31'd0, out_valid}, 32'd1);
      if (k == 0) begin
        check_eq("deadbeef_busy", {31'd0, busy}, 32'd1);
        check_eq("deadbeef_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
    end
    @(negedge clk);
    check_eq("deadbeef_end_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("deadbeef_end_busy", {31'd0, busy}, 32'd0);
    check_eq("deadbeef_end_valid", {31'd0, out_valid}, 32'd0);

    // Trimmed words, including all-zero
    push_seq(4, 80'({8'h41, 8'h35, 8'h0D, 8'h0A}));
    send(32'h000000A5, 1'b1);
    wait_drain("drain_a5");
    push_seq(3, 80'({8'h30, 8'h0D, 8'h0A}));
    send(32'h00000000, 1'b1);
    wait_drain("drain_zero");

    // Backpressure
    bp_en = 1'b1;
    push_seq(10, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A});
    send(32'h12345678, 1'b0);
    wait_drain("drain_backpressure");
    bp_en = 1'b0;

    // New word offered during a stream must wait for in_ready
    push_seq(10, {8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A});
    push_seq(3, 80'({8'h39, 8'h0D, 8'h0A}));
    send(32'h0000ABCD, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h00000009;
    in_trim  = 1'b1;
    @(negedge clk);
    check_eq("overlap_in_ready_low", {31'd0, in_ready}, 32'd0);
    send(32'h00000009, 1'b1);
    wait_drain("drain_overlap");

    // Reset mid-stream after the third byte
    push_seq(10, {8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44, 8'h0D, 8'h0A});
    base = n_hs;
    send(32'hCAFEF00D, 1'b0);
    guard = 0;
    @(negedge clk); #1;
    while (n_hs < base + 3 + PFX && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (n_hs < base + 3 + PFX) timeout_fail("reset_wait_bytes");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst_out_char", {24'd0, out_char}, 32'h00);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_seq(3, 80'({8'h31, 8'h0D, 8'h0A}));
    send(32'h00000001, 1'b1);
    wait_drain("drain_post_reset");

    repeat (3) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
